// File: rtl/rng_pkg.sv
// Shared definitions for the range sampler: defaults, FSM state encoding and
// the seed substituted for an all-zero seed.
package rng_pkg;

    localparam int         S_WIDTH_DEF   = 8;
    localparam int         MAX_TRIES_DEF = 8;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

    typedef enum logic [2:0] {
        SEED = 3'd0,
        WARM = 3'd1,
        IDLE = 3'd2,
        DRAW = 3'd3,
        HOLD = 3'd4
    } state_e;

endpackage

// File: rtl/rng_mask_gen.sv
// Maps an exclusive bound N to the smallest all-ones mask covering N-1.
// N=0 wraps to N-1 = all ones, which is exactly the full-range mask.
module rng_mask_gen
    import rng_pkg::*;
#(
    parameter int S_WIDTH = S_WIDTH_DEF
) (
    input  logic [S_WIDTH-1:0] bound_i,
    output logic [S_WIDTH-1:0] mask_o
);

    always_comb begin
        mask_o = bound_i - S_WIDTH'(1);
        // Smear the top set bit downwards so every lower bit is filled.
        for (int i = 1; i < S_WIDTH; i = i * 2) begin
            mask_o = mask_o | (mask_o >> i);
        end
    end

endmodule

// File: rtl/rng_range_sampler.sv
// Rejection sampler turning a free-running random word into a uniform value in
// [0, N-1]. Define RNG_SAMPLER_STATS_EN to add the reject_cnt_o statistics port.
module rng_range_sampler
    import rng_pkg::*;
#(
    parameter int S_WIDTH   = S_WIDTH_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [S_WIDTH-1:0] seed_i,
    input  logic               seed_load_i,
    output logic [S_WIDTH-1:0] lfsr_seed_o,
    output logic               lfsr_seed_valid_o,
    output logic [1:0]         lfsr_mode_o,
    input  logic [S_WIDTH-1:0] lfsr_num_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [S_WIDTH-1:0] req_bound_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [S_WIDTH-1:0] rsp_num_o,
    output logic               rsp_fallback_o
`ifdef RNG_SAMPLER_STATS_EN
    ,
    output logic [15:0]        reject_cnt_o
`endif
);

    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    function automatic logic [S_WIDTH-1:0] seed_fix(input logic [S_WIDTH-1:0] s);
        return (s == '0) ? S_WIDTH'(ZERO_SEED_SUB) : s;
    endfunction

    state_e             state_q, state_d;
    logic               seed_valid_q;
    logic [S_WIDTH-1:0] seed_q;
    logic               reseed_pending_q;
    logic [S_WIDTH-1:0] pend_seed_q;
    logic               warm_q;
    logic [S_WIDTH-1:0] bound_q;
    logic [TRY_W-1:0]   try_q;
    logic [S_WIDTH-1:0] num_q;
    logic               fb_q;
    logic [S_WIDTH-1:0] mask;
    logic [S_WIDTH-1:0] masked;
    logic               accept;
    logic               last_try;
    logic               hs;
    logic               strobe_set;

    rng_mask_gen #(.S_WIDTH(S_WIDTH)) u_mask_gen (
        .bound_i (bound_q),
        .mask_o  (mask)
    );

    assign masked     = lfsr_num_i & mask;
    assign accept     = (bound_q == '0) || (masked < bound_q);
    assign last_try   = (try_q == LAST_TRY);
    assign hs         = req_valid_i && req_ready_o;
    // The strobe is raised on the last SEED cycle; reset entry spends one
    // extra SEED cycle so the strobe never overlaps the reset itself.
    assign strobe_set = (state_d == SEED) && !seed_valid_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SEED: if (seed_valid_q) state_d = WARM;
            WARM: if (warm_q) state_d = IDLE;
            IDLE: begin
                if (seed_load_i || reseed_pending_q) state_d = SEED;
                else if (req_valid_i)                state_d = DRAW;
            end
            DRAW: if (accept || last_try) state_d = HOLD;
            HOLD: begin
                if (rsp_ready_i) state_d = (reseed_pending_q || seed_load_i) ? SEED : IDLE;
            end
            default: state_d = SEED;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE) && !seed_load_i && !reseed_pending_q;
        rsp_valid_o = (state_q == HOLD);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            seed_valid_q     <= 1'b0;
            seed_q           <= '0;
            reseed_pending_q <= 1'b0;
            warm_q           <= 1'b0;
            try_q            <= '0;
            num_q            <= '0;
            fb_q             <= 1'b0;
        end else begin
            seed_valid_q <= strobe_set;
            warm_q       <= (state_q == WARM) ? ~warm_q : 1'b0;
            if (strobe_set) begin
                seed_q           <= seed_fix((seed_load_i || !reseed_pending_q) ? seed_i : pend_seed_q);
                reseed_pending_q <= 1'b0;
            end else if (seed_load_i) begin
                reseed_pending_q <= 1'b1;
            end
            if (hs) begin
                try_q <= '0;
            end else if (state_q == DRAW && !accept) begin
                try_q <= try_q + TRY_W'(1);
            end
            // masked - N is always below N because mask < 2N.
            if (state_q == DRAW && (accept || last_try)) begin
                num_q <= accept ? masked : masked - bound_q;
                fb_q  <= !accept;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!strobe_set && seed_load_i) pend_seed_q <= seed_i;
        if (hs)                         bound_q     <= req_bound_i;
    end

`ifdef RNG_SAMPLER_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [15:0] reject_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            reject_cnt_q <= '0;
        end else if (state_q == SEED) begin
            reject_cnt_q <= '0;
        end else if (state_q == DRAW && !accept) begin
            reject_cnt_q <= sat_inc16(reject_cnt_q);
        end
    end

    assign reject_cnt_o = reject_cnt_q;
`endif

    assign lfsr_mode_o       = 2'b00;
    assign lfsr_seed_o       = seed_q;
    assign lfsr_seed_valid_o = seed_valid_q;
    assign rsp_num_o         = num_q;
    assign rsp_fallback_o    = fb_q;

endmodule

// File: tb/tb_rng_range_sampler.sv
// Randomised bench for rng_range_sampler with a transaction-level reference
// model and directed cases for reset, seeding, fallback and bound edges.
module tb_rng_range_sampler;

    localparam int SW    = 8;
    localparam int MT    = 8;
    localparam int SEQ_N = 4096;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [SW-1:0] seed_i;
    logic          seed_load_i;
    logic [SW-1:0] lfsr_seed_o;
    logic          lfsr_seed_valid_o;
    logic [1:0]    lfsr_mode_o;
    logic [SW-1:0] lfsr_num_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [SW-1:0] req_bound_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [SW-1:0] rsp_num_o;
    logic          rsp_fallback_o;
`ifdef RNG_SAMPLER_STATS_EN
    logic [15:0]   reject_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int seq [SEQ_N];

    rng_range_sampler #(.S_WIDTH(SW), .MAX_TRIES(MT)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .seed_i            (seed_i),
        .seed_load_i       (seed_load_i),
        .lfsr_seed_o       (lfsr_seed_o),
        .lfsr_seed_valid_o (lfsr_seed_valid_o),
        .lfsr_mode_o       (lfsr_mode_o),
        .lfsr_num_i        (lfsr_num_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_bound_i       (req_bound_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_num_o         (rsp_num_o),
        .rsp_fallback_o    (rsp_fallback_o)
`ifdef RNG_SAMPLER_STATS_EN
        ,
        .reject_cnt_o      (reject_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic int fix_seed(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    // Reference: mask is the smallest 2^k-1 reaching N-1; first draw below N wins,
    // otherwise the last draw minus N is returned as the fallback.
    function automatic void predict(input int n, input int vals[MT], output int num,
                                    output bit fb, output int lat, output int rej);
        int nn, m, v;
        nn = (n == 0) ? 256 : n;
        m  = 0;
        while (m < nn - 1) m = m * 2 + 1;
        for (int k = 0; k < MT; k++) begin
            v = vals[k] & m;
            if (v < nn) begin
                num = v; fb = 1'b0; lat = k + 2; rej = k;
                return;
            end
        end
        num = (vals[MT-1] & m) - nn;
        fb  = 1'b1;
        lat = MT + 1;
        rej = MT;
    endfunction

    // Random-word source: value seq[c] is presented during cycle c.
    initial begin
        for (int i = 0; i < SEQ_N; i++) seq[i] = int'($urandom_range(255));
        lfsr_num_i = SW'(seq[0]);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            lfsr_num_i = SW'(seq[cyc % SEQ_N]);
        end
    end

    // Compare process: every cycle, response outputs against the model.
    bit outstanding = 1'b0;
    int exp_start, exp_num, exp_seed;
    bit exp_fb;
`ifdef RNG_SAMPLER_STATS_EN
    int exp_rej = 0;
`endif
    always @(negedge clk) begin
        int  vals[MT];
        int  p_num, p_lat, p_rej;
        bit  p_fb, exp_valid;
        if (!rst_i) begin
            outstanding = 1'b0;
            exp_seed    = int'(seed_i);
`ifdef RNG_SAMPLER_STATS_EN
            exp_rej     = 0;
`endif
            chk(rsp_valid_o == 1'b0, "rst_rsp_valid", int'(rsp_valid_o), 0);
        end else begin
            if (lfsr_seed_valid_o) begin
                chk(int'(lfsr_seed_o) == fix_seed(exp_seed), "seed_value", int'(lfsr_seed_o), fix_seed(exp_seed));
`ifdef RNG_SAMPLER_STATS_EN
                exp_rej = 0;
`endif
            end
            if (seed_load_i) exp_seed = int'(seed_i);
            exp_valid = outstanding && (cyc >= exp_start);
            chk(rsp_valid_o == exp_valid, "rsp_valid", int'(rsp_valid_o), int'(exp_valid));
            if (exp_valid && rsp_valid_o) begin
                chk(int'(rsp_num_o) == exp_num, "rsp_num", int'(rsp_num_o), exp_num);
                chk(rsp_fallback_o == exp_fb, "rsp_fallback", int'(rsp_fallback_o), int'(exp_fb));
`ifdef RNG_SAMPLER_STATS_EN
                chk(int'(reject_cnt_o) == ((exp_rej > 65535) ? 65535 : exp_rej), "reject_cnt",
                    int'(reject_cnt_o), exp_rej);
`endif
            end
            chk(!(req_ready_o && (outstanding || seed_load_i)), "req_ready_gate", int'(req_ready_o), 0);
            if (exp_valid && rsp_valid_o && rsp_ready_i) outstanding = 1'b0;
            if (req_valid_i && req_ready_o) begin
                for (int i = 0; i < MT; i++) vals[i] = seq[(cyc + 1 + i) % SEQ_N];
                predict(int'(req_bound_i), vals, p_num, p_fb, p_lat, p_rej);
                outstanding = 1'b1;
                exp_start   = cyc + p_lat;
                exp_num     = p_num;
                exp_fb      = p_fb;
`ifdef RNG_SAMPLER_STATS_EN
                exp_rej     = exp_rej + p_rej;
`endif
            end
        end
    end

    task automatic wait_ready;
        int w = 0;
        while (!req_ready_o && w < 50) begin
            tick;
            w++;
        end
        chk(req_ready_o == 1'b1, "req_ready_wait", int'(req_ready_o), 1);
    endtask

    task automatic directed(input int n, input int vals[MT], input int nv, input int e_num,
                            input bit e_fb, input int e_lat, input string tag);
        int lat;
        wait_ready;
        for (int i = 0; i < nv; i++) seq[(cyc + 1 + i) % SEQ_N] = vals[i];
        req_valid_i = 1'b1;
        req_bound_i = SW'(n);
        tick;
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            tick;
            lat++;
        end
        chk(lat == e_lat, {tag, "_latency"}, lat, e_lat);
        chk(int'(rsp_num_o) == e_num, {tag, "_num"}, int'(rsp_num_o), e_num);
        chk(rsp_fallback_o == e_fb, {tag, "_fallback"}, int'(rsp_fallback_o), int'(e_fb));
`ifdef RNG_SAMPLER_STATS_EN
        if (tag == "n129") chk(reject_cnt_o == 16'd8, "n129_reject_cnt", int'(reject_cnt_o), 8);
`endif
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int v[MT];
        int p_num, p_lat, p_rej, w, n, pct;
        bit p_fb, done, reseed;

        rst_i = 1'b0; seed_i = '0; seed_load_i = 1'b0;
        req_valid_i = 1'b0; req_bound_i = '0; rsp_ready_i = 1'b0;

        // Model pins, hand-computed.
        v = '{7, 6, 12, 0, 0, 0, 0, 0};
        predict(5, v, p_num, p_fb, p_lat, p_rej);
        chk(p_num == 4 && p_lat == 4 && !p_fb, "model_n5", p_num, 4);
        v = '{200, 200, 200, 200, 200, 200, 200, 200};
        predict(129, v, p_num, p_fb, p_lat, p_rej);
        chk(p_num == 71 && p_lat == 9 && p_fb, "model_n129", p_num, 71);
        v = '{255, 0, 0, 0, 0, 0, 0, 0};
        predict(0, v, p_num, p_fb, p_lat, p_rej);
        chk(p_num == 255 && p_lat == 2, "model_n0", p_num, 255);
        v = '{171, 0, 0, 0, 0, 0, 0, 0};
        predict(1, v, p_num, p_fb, p_lat, p_rej);
        chk(p_num == 0 && p_lat == 2, "model_n1", p_num, 0);

        repeat (3) tick;
        chk(req_ready_o == 1'b0, "rst_req_ready", int'(req_ready_o), 0);
        chk(rsp_num_o == '0, "rst_rsp_num", int'(rsp_num_o), 0);
        chk(rsp_fallback_o == 1'b0, "rst_rsp_fallback", int'(rsp_fallback_o), 0);
        chk(lfsr_seed_valid_o == 1'b0, "rst_seed_valid", int'(lfsr_seed_valid_o), 0);
        chk(lfsr_seed_o == '0, "rst_seed_o", int'(lfsr_seed_o), 0);
        chk(lfsr_mode_o == 2'b00, "lfsr_mode", int'(lfsr_mode_o), 0);

        // Zero seed at reset release: substituted seed, one strobe, ready 3 cycles later.
        rst_i = 1'b1;
        w = 0;
        while (!lfsr_seed_valid_o && w < 10) begin
            tick;
            w++;
        end
        chk(lfsr_seed_valid_o == 1'b1, "boot_strobe", int'(lfsr_seed_valid_o), 1);
        chk(lfsr_seed_o == 8'h01, "boot_seed_sub", int'(lfsr_seed_o), 1);
        tick;
        chk(lfsr_seed_valid_o == 1'b0, "boot_strobe_single", int'(lfsr_seed_valid_o), 0);
        w = 1;
        while (!req_ready_o && w < 10) begin
            tick;
            w++;
        end
        chk(w == 3, "boot_ready_delay", w, 3);

        v = '{200, 200, 200, 200, 200, 200, 200, 200};
        directed(129, v, 8, 71, 1'b1, 9, "n129");
        v = '{7, 6, 12, 0, 0, 0, 0, 0};
        directed(5, v, 3, 4, 1'b0, 4, "n5");
        v = '{255, 0, 0, 0, 0, 0, 0, 0};
        directed(0, v, 1, 255, 1'b0, 2, "n0");
        v = '{int'($urandom_range(255)), 0, 0, 0, 0, 0, 0, 0};
        directed(1, v, 1, 0, 1'b0, 2, "n1");

        // Reseed during DRAW with a slow consumer.
        wait_ready;
        seq[(cyc + 1) % SEQ_N] = 7;
        seq[(cyc + 2) % SEQ_N] = 7;
        seq[(cyc + 3) % SEQ_N] = 2;
        req_valid_i = 1'b1; req_bound_i = 8'd5;
        tick;
        req_valid_i = 1'b0; seed_load_i = 1'b1; seed_i = 8'h5A;
        tick;
        seed_load_i = 1'b0;
        w = 0;
        while (!rsp_valid_o && w < 20) begin
            tick;
            w++;
        end
        for (int i = 0; i < 3; i++) begin
            chk(rsp_valid_o == 1'b1, "hold_valid", int'(rsp_valid_o), 1);
            chk(rsp_num_o == 8'd2, "hold_num", int'(rsp_num_o), 2);
            tick;
        end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        chk(lfsr_seed_valid_o == 1'b1, "reseed_strobe", int'(lfsr_seed_valid_o), 1);
        chk(lfsr_seed_o == 8'h5A, "reseed_value", int'(lfsr_seed_o), 'h5A);
        chk(rsp_valid_o == 1'b0, "reseed_rsp_drop", int'(rsp_valid_o), 0);
        tick;
        chk(req_ready_o == 1'b0, "warm1_ready", int'(req_ready_o), 0);
        tick;
        chk(req_ready_o == 1'b0, "warm2_ready", int'(req_ready_o), 0);
        tick;
        chk(req_ready_o == 1'b1, "post_warm_ready", int'(req_ready_o), 1);

        // Seed load and request in the same IDLE cycle.
        wait_ready;
        seed_load_i = 1'b1; seed_i = 8'h3C; req_valid_i = 1'b1; req_bound_i = 8'd7;
        #1;
        chk(req_ready_o == 1'b0, "collide_ready", int'(req_ready_o), 0);
        tick;
        seed_load_i = 1'b0; req_valid_i = 1'b0;
        chk(lfsr_seed_valid_o == 1'b1, "collide_strobe", int'(lfsr_seed_valid_o), 1);
        chk(lfsr_seed_o == 8'h3C, "collide_seed", int'(lfsr_seed_o), 'h3C);

        // Reset in the middle of DRAW.
        wait_ready;
        for (int i = 1; i <= 4; i++) seq[(cyc + i) % SEQ_N] = 7;
        req_valid_i = 1'b1; req_bound_i = 8'd5;
        tick;
        req_valid_i = 1'b0;
        tick;
        rst_i = 1'b0;
        #1;
        chk(rsp_valid_o == 1'b0, "rst_draw_valid", int'(rsp_valid_o), 0);
        tick;
        chk(rsp_valid_o == 1'b0 && req_ready_o == 1'b0, "rst_draw_hold", int'(rsp_valid_o), 0);
        rst_i = 1'b1;

        // Randomised traffic.
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(5))
                0:       n = 0;
                1:       n = 1;
                2:       n = 129;
                3:       n = int'($urandom_range(2, 16));
                default: n = int'($urandom_range(255));
            endcase
            pct    = int'($urandom_range(30, 100));
            reseed = ($urandom_range(7) == 0);
            wait_ready;
            if (n == 129 && $urandom_range(1) == 1)
                for (int i = 1; i <= MT; i++) seq[(cyc + i) % SEQ_N] = int'($urandom_range(129, 255));
            req_valid_i = 1'b1;
            req_bound_i = SW'(n);
            tick;
            req_valid_i = 1'b0;
            req_bound_i = SW'($urandom_range(255));
            done = 1'b0;
            w = 0;
            while (!done && w < 60) begin
                rsp_ready_i = ($urandom_range(99) < pct);
                seed_load_i = reseed && (w == 0);
                if (seed_load_i) seed_i = ($urandom_range(3) == 0) ? '0 : SW'($urandom_range(255));
                done = rsp_valid_o && rsp_ready_i;
                tick;
                w++;
            end
            seed_load_i = 1'b0;
            rsp_ready_i = 1'b0;
            chk(done, "rsp_complete", int'(done), 1);
        end

        repeat (5) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rng_range_sampler.md
RNG_RANGE_SAMPLER -- requirements
Module: rng_range_sampler

Interface
REQ-001 SHALL have parameter S_WIDTH, default 8, random/bound word width.
REQ-002 SHALL have parameter MAX_TRIES, default 8, number of rejected draws before the fallback is used.
REQ-003 SHALL have port clk_i  in  1  clock; reset rst_i, asynchronous, active-low.
REQ-004 SHALL have port rst_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have port seed_i  in  S_WIDTH  seed value for the generator.
REQ-006 SHALL have port seed_load_i  in  1  one-cycle request to reseed the generator.
REQ-007 SHALL have port lfsr_seed_o  out  S_WIDTH  seed driven to the generator.
REQ-008 SHALL have port lfsr_seed_valid_o  out  1  seed load strobe to the generator.
REQ-009 SHALL have port lfsr_mode_o  out  2  generator mode; constant 2'b00 (full range).
REQ-010 SHALL have port lfsr_num_i  in  S_WIDTH  registered random word; fresh every cycle.
REQ-011 SHALL have port req_valid_i / req_ready_o  in / out  1 / 1  request handshake.
REQ-012 SHALL have port req_bound_i  in  S_WIDTH  exclusive upper bound N; 0 means 2^S_WIDTH.
REQ-013 SHALL have port rsp_valid_o / rsp_ready_i  out / in  1 / 1  response handshake.
REQ-014 SHALL have port rsp_num_o  out  S_WIDTH  sample, uniform in [0, N-1].
REQ-015 SHALL have port rsp_fallback_o  out  1  high when the sample came from the fallback path.

Function
REQ-016 SHALL implement FSM states SEED, WARM, IDLE, DRAW, HOLD.
REQ-017 SEED SHALL drive lfsr_seed_valid_o=1 for exactly one cycle; then go to WARM.
REQ-018 SEED SHALL substitute seed 0 with 8'h01, because a zero seed locks up the generator.
REQ-019 WARM SHALL last 2 cycles (generator load plus output register); then go to IDLE.
REQ-020 req_ready_o SHALL equal (state==IDLE) & !seed_load_i & !reseed_pending.
REQ-021 On a handshake, the block SHALL latch the bound, compute mask = smallest 2^k-1 >= N-1 (N=0 gives all ones), clear the try counter, and go to DRAW.
REQ-022 Each DRAW cycle SHALL sample lfsr_num_i.
  - Accept when (lfsr_num_i & mask) < N, or when N==0.
  - On accept: rsp_num_o <= masked value, rsp_fallback_o <= 0, go to HOLD.
REQ-023 A rejected draw SHALL increment the try counter; when the counter reaches MAX_TRIES-1 on a reject, rsp_num_o <= masked - N (always < N), rsp_fallback_o <= 1, go to HOLD.
REQ-024 N==1 SHALL give rsp_num_o=0 after one DRAW cycle.
REQ-025 Minimum latency SHALL be 2 cycles from request handshake to rsp_valid_o; maximum SHALL be MAX_TRIES+1 cycles.
REQ-026 HOLD SHALL assert rsp_valid_o and keep rsp_num_o/rsp_fallback_o stable until rsp_ready_i; then go to IDLE, or to SEED if a reseed is pending.
REQ-027 seed_load_i in IDLE SHALL go to SEED and win over a same-cycle req_valid_i (no handshake that cycle).
REQ-028 seed_load_i in SEED, WARM, DRAW or HOLD SHALL set reseed_pending and capture seed_i; the latest capture wins.
REQ-029 The pending reseed SHALL be serviced on the next entry to IDLE, and the in-flight request SHALL complete first.

Reset
REQ-030 On rst_i low, the block SHALL enter SEED using seed_i; at release this gives one seed strobe, then 2 WARM cycles, then IDLE.
REQ-031 Reset values SHALL be: req_ready_o=0, rsp_valid_o=0, rsp_num_o=0, rsp_fallback_o=0, lfsr_seed_valid_o=0, lfsr_seed_o=0, reseed_pending=0, try counter=0.
REQ-032 Reset mid-DRAW or mid-HOLD SHALL drop the response with no rsp_valid_o glitch.

Configuration
REQ-033 When RNG_SAMPLER_STATS_EN is defined, the block SHALL add output reject_cnt_o (16 bits).
  - Counts rejected draws; saturates at 16'hFFFF.
  - Reset to 0 by rst_i and on each SEED.
REQ-034 When RNG_SAMPLER_STATS_EN is undefined, the port and its counter SHALL be absent.

Structure
REQ-035 Package rng_pkg SHALL hold the S_WIDTH default, the state enum, the MAX_TRIES default, and the constant ZERO_SEED_SUB=8'h01.
REQ-036 Combinational sub-module rng_mask_gen SHALL map bound to mask; rng_range_sampler instantiates it once.

Verification
REQ-037 Reset release, seed_i=8'h00: lfsr_seed_o=8'h01 with one strobe cycle, req_ready_o=1 exactly 3 cycles after SEED.
REQ-038 N=5, lfsr_num_i sequence 07,06,0C: two rejects, then rsp_num_o=4, rsp_fallback_o=0, rsp_valid_o 4 cycles after the handshake.
REQ-039 N=129, lfsr_num_i held at 200 for 8 draws: rsp_num_o=71, rsp_fallback_o=1; with the macro, reject_cnt_o=8.
REQ-040 N=0 with lfsr_num_i=8'hFF, and N=1 with any input: accept on the first draw; outputs 255 and 0.
REQ-041 seed_load_i pulse during DRAW, rsp_ready_i held low 3 cycles: response stays stable, then SEED follows HOLD, and req_ready_o stays low until WARM ends.
REQ-042 seed_load_i and req_valid_i together in IDLE: no request handshake that cycle, and a seed strobe on the next cycle.
